// File: rtl/ibuffer_queue.sv
// Instruction buffer: circular FIFO between fetch and the control block.
// Define IBUFFER_BYPASS_EN to forward an enqueue straight to the outputs when the queue is empty.
module ibuffer_queue #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned PC_W   = 48,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic [INST_W-1:0]        fetch_inst,
  input  logic [PC_W-1:0]          fetch_pc,
  output logic                     ibuffer_instr_valid,
  input  logic                     ibuffer_instr_ready,
  output logic [INST_W-1:0]        ibuffer_inst_out,
  output logic [PC_W-1:0]          ibuffer_pc_out,
  output logic [$clog2(DEPTH):0]   ibuffer_count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]   count;
  logic [AddrW-1:0]  wr_idx, rd_idx;
  logic              empty, full;
  logic              head_valid, bypass_sel;
  logic              enq, deq;

  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   pc_mem   [DEPTH];

  // Pointer MSB distinguishes full from empty, so the difference spans 0..DEPTH.
  assign count  = wr_ptr_q - rd_ptr_q;
  assign wr_idx = wr_ptr_q[AddrW-1:0];
  assign rd_idx = rd_ptr_q[AddrW-1:0];
  assign empty  = (count == '0);
  assign full   = (count == PtrW'(DEPTH));

  assign fetch_ready = !full && !flush;
  assign head_valid  = !empty && !flush && !reset;

`ifdef IBUFFER_BYPASS_EN
  assign bypass_sel = empty && fetch_valid && !flush && !reset;
`else
  assign bypass_sel = 1'b0;
`endif

  assign ibuffer_instr_valid = head_valid || bypass_sel;
  assign ibuffer_count       = reset ? '0 : count;

  // A bypassed entry that is consumed in the same cycle never touches storage.
  assign enq = fetch_valid && fetch_ready && !reset && !(bypass_sel && ibuffer_instr_ready);
  assign deq = head_valid && ibuffer_instr_ready;

  always_comb begin
    ibuffer_inst_out = '0;
    ibuffer_pc_out   = '0;
    if (reset) begin
      ibuffer_inst_out = '0;
      ibuffer_pc_out   = '0;
    end else if (bypass_sel) begin
      ibuffer_inst_out = fetch_inst;
      ibuffer_pc_out   = fetch_pc;
    end else if (!empty) begin
      ibuffer_inst_out = inst_mem[rd_idx];
      ibuffer_pc_out   = pc_mem[rd_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PtrW'(enq);
      rd_ptr_q <= rd_ptr_q + PtrW'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (enq) begin
      inst_mem[wr_idx] <= fetch_inst;
      pc_mem[wr_idx]   <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_ibuffer_queue.sv
// Scoreboard bench for ibuffer_queue: a driver pushes expected entries, a monitor pops and compares.
module tb_ibuffer_queue;

  localparam int unsigned Depth = 8;
`ifdef IBUFFER_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [47:0] pc;
  } entry_t;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_inst;
  logic [47:0] fetch_pc;
  logic        ibuffer_instr_valid;
  logic        ibuffer_instr_ready;
  logic [31:0] ibuffer_inst_out;
  logic [47:0] ibuffer_pc_out;
  logic [3:0]  ibuffer_count;

  ibuffer_queue #(
    .INST_W (32),
    .PC_W   (48),
    .DEPTH  (Depth)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .flush               (flush),
    .fetch_valid         (fetch_valid),
    .fetch_ready         (fetch_ready),
    .fetch_inst          (fetch_inst),
    .fetch_pc            (fetch_pc),
    .ibuffer_instr_valid (ibuffer_instr_valid),
    .ibuffer_instr_ready (ibuffer_instr_ready),
    .ibuffer_inst_out    (ibuffer_inst_out),
    .ibuffer_pc_out      (ibuffer_pc_out),
    .ibuffer_count       (ibuffer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  entry_t sb[$];
  int     pre_count = 0;
  bit     started = 1'b0;
  int     checks = 0;
  int     failures = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Drive one cycle of inputs; the model accepts an enqueue when not full and not flushed/reset.
  task automatic cycle(input bit fv, input logic [31:0] i, input logic [47:0] p,
                       input bit rdy, input bit fl, input bit rs);
    @(negedge clock);
    fetch_valid         = fv;
    fetch_inst          = i;
    fetch_pc            = p;
    ibuffer_instr_ready = rdy;
    flush               = fl;
    reset               = rs;
    #1;
    pre_count = sb.size();
    if (fv && !fl && !rs && pre_count != Depth) sb.push_back('{inst: i, pc: p});
    started = 1'b1;
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 32'h0, 48'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic fill(input int n, input logic [47:0] base);
    for (int k = 0; k < n; k++) cycle(1'b1, $urandom, base + 48'(4 * k), 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare the DUT's presented state with the model, pop on handshake.
  always begin
    bit exp_valid;
    @(negedge clock);
    #2;
    if (started) begin
      exp_valid = !reset && !flush && (Bypass ? (sb.size() > 0) : (pre_count > 0));
      check("valid", 64'(ibuffer_instr_valid), 64'(exp_valid));
      check("count", 64'(ibuffer_count), reset ? 64'd0 : 64'(pre_count));
      if (!reset)
        check("fetch_ready", 64'(fetch_ready), 64'((pre_count != Depth) && !flush));
      if (exp_valid) begin
        check("inst_out", 64'(ibuffer_inst_out), 64'(sb[0].inst));
        check("pc_out", 64'(ibuffer_pc_out), 64'(sb[0].pc));
        if (ibuffer_instr_ready) void'(sb.pop_front());
      end else if (reset || pre_count == 0) begin
        check("inst_zero", 64'(ibuffer_inst_out), 64'd0);
        check("pc_zero", 64'(ibuffer_pc_out), 64'd0);
      end
      if (reset || flush) sb.delete();
    end
  end

  initial begin
    int thr;
    reset = 1'b1;
    flush = 1'b0;
    fetch_valid = 1'b0;
    fetch_inst = '0;
    fetch_pc = '0;
    ibuffer_instr_ready = 1'b0;

    repeat (2) cycle(1'b0, 32'h0, 48'h0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // First instruction visible one cycle after enqueue.
    cycle(1'b1, 32'h0000_0013, 48'h8000_0000, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    repeat (2) idle(1'b1);

    // Fill to full, ninth enqueue must be refused, then drain in order.
    fill(9, 48'h1000);
    repeat (10) idle(1'b1);

    // Steady occupancy 3 with simultaneous enqueue and dequeue.
    fill(3, 48'h2000);
    for (int k = 0; k < 20; k++) cycle(1'b1, $urandom, 48'h3000 + 48'(4 * k), 1'b1, 1'b0, 1'b0);
    repeat (4) idle(1'b1);

    // Flush at occupancy 5 with traffic on both sides.
    fill(5, 48'h4000);
    cycle(1'b1, 32'h1111_1111, 48'h5000, 1'b1, 1'b1, 1'b0);
    idle(1'b0);

    // Reset mid-stream at occupancy 4.
    fill(4, 48'h6000);
    cycle(1'b1, 32'h2222_2222, 48'h7000, 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Empty queue with enqueue and consumer ready in the same cycle.
    cycle(1'b1, 32'hDEAD_BEEF, 48'h9000, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    repeat (2) idle(1'b1);

    // Random traffic with varying consumer pressure, rare flushes and resets.
    for (int w = 0; w < 15; w++) begin
      thr = int'($urandom_range(90, 10));
      for (int k = 0; k < 100; k++) begin
        cycle(($urandom_range(99) < 70), $urandom, {16'($urandom), $urandom},
              (int'($urandom_range(99)) < thr), ($urandom_range(39) == 0),
              ($urandom_range(99) == 0));
      end
    end
    repeat (10) idle(1'b1);

    @(negedge clock);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
